uart_tx_param: RTL

UART_TX_PARAM -- requirements
Module: uart_tx_param

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_cnt.sv | 29 ++
 rtl/uart_tx_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and legality limits for the parameterised UART transmitter.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int unsigned UART_MIN_DATA_BITS    = 5;
  localparam int unsigned UART_MAX_DATA_BITS    = 9;
  localparam int unsigned UART_MIN_STOP_BITS    = 1;
  localparam int unsigned UART_MAX_STOP_BITS    = 2;
  localparam int unsigned UART_MIN_CLKS_PER_BIT = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_tx_state_t;

  function automatic bit uart_data_bits_ok(input int unsigned n);
    return (n >= UART_MIN_DATA_BITS) && (n <= UART_MAX_DATA_BITS);
  endfunction

  function automatic bit uart_stop_bits_ok(input int unsigned n);
    return (n >= UART_MIN_STOP_BITS) && (n <= UART_MAX_STOP_BITS);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while clear is low and pulses
// bit_end on the final count, then wraps to zero.
module uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_end = !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter (start, DATA_BITS LSB first, optional parity,
// STOP_BITS stop bits). Parity is compiled in with `define UART_TX_PARITY_EN.
//
// state     | meaning
// ----------|----------------------------------------------------------
// ST_IDLE   | line high, ready for a word; tx_done high on first cycle
// ST_START  | start bit (tx=0) for one bit period
// ST_DATA   | data bits, LSB first, one bit period each
// ST_PARITY | parity bit for one bit period (parity builds only)
// ST_STOP   | tx=1 for STOP_BITS bit periods
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 100000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  if (CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) begin : g_bad_clks
    $error("uart_tx_param: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end
  if (!uart_data_bits_ok(DATA_BITS)) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (!uart_stop_bits_ok(STOP_BITS)) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1..2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_q, stop_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  // Counter is held at zero in IDLE so the start bit gets a full period.
  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == ST_IDLE),
    .bit_end(bit_end)
  );

  assign ready   = (state_q == ST_IDLE);
  assign tx_busy = ~ready;
  assign tx      = tx_q;
  assign tx_done = done_q;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (valid) begin
          shift_d  = data_in;
          idx_d    = '0;
          stop_d   = 1'b0;
          tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d = (^data_in) ^ PARITY_ODD[0];
`endif
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (idx_q == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = ST_PARITY;
`else
            tx_d    = 1'b1;
            state_d = ST_STOP;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            stop_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      idx_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
